// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// Defining ILLEGAL_HALT_EN adds the HALT state used for illegal instructions.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned SRCB_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_R   = 4'd7,
    S_EXEC_I = 4'd8,
    S_WB_I   = 4'd9,
    S_BRANCH = 4'd10
`ifdef ILLEGAL_HALT_EN
    , S_HALT = 4'd11
`endif
  } state_t;

  // Which ALU operation source a state needs
  typedef enum logic [2:0] {
    ALU_CLS_NONE,
    ALU_CLS_ADD,
    ALU_CLS_SUB,
    ALU_CLS_R,
    ALU_CLS_I
  } alu_cls_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_NOR = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_W-1:0] ALU_NOR = 4'd12;

  localparam logic [SRCB_W-1:0] SRCB_REG    = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_IMM_HI = 2'b11;

  function automatic logic is_itype(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU operation select for the controller, with an illegal
// flag for unsupported funct/opcode encodings.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_cls_t         cls,
  input  logic [OP_W-1:0]  opcode,
  input  logic [OP_W-1:0]  funct,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal
);

  always_comb begin
    alu_control = ALU_AND;
    illegal     = 1'b0;
    case (cls)
      ALU_CLS_ADD: alu_control = ALU_ADD;
      ALU_CLS_SUB: alu_control = ALU_SUB;
      ALU_CLS_R: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_NOR:  alu_control = ALU_NOR;
          FN_SLT:  alu_control = ALU_SLT;
          default: illegal     = 1'b1;
        endcase
      end
      ALU_CLS_I: begin
        // lui adds the shifted immediate to $0
        case (opcode)
          OP_ADDI: alu_control = ALU_ADD;
          OP_SLTI: alu_control = ALU_SLT;
          OP_ANDI: alu_control = ALU_AND;
          OP_ORI:  alu_control = ALU_OR;
          OP_LUI:  alu_control = ALU_ADD;
          default: illegal     = 1'b1;
        endcase
      end
      default: alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_mc_control_unit.sv
// Moore FSM controller for the multi-cycle MIPS datapath.
// ILLEGAL_HALT_EN: illegal instructions halt the controller instead of acting as NOPs.
module mips_mc_control_unit
  import mips_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     Opcode,
  input  logic [OP_W-1:0]     Funct,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                Branch,
  output logic                PCSrc,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic [SRCB_W-1:0]   ALUSrcB,
  output logic [ALU_W-1:0]    ALUControl,
  output logic                Halted_o,
  output logic [STATE_W-1:0]  State_o
);

`ifdef ILLEGAL_HALT_EN
  localparam state_t ILL_NEXT = S_HALT;
`else
  localparam state_t ILL_NEXT = S_FETCH;
`endif

  state_t           state_q;
  state_t           state_d;
  alu_cls_t         alu_cls;
  logic [ALU_W-1:0] alu_ctrl;
  logic             alu_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // ALU source class depends on the state register alone
  always_comb begin
    alu_cls = ALU_CLS_NONE;
    case (state_q)
      S_FETCH, S_DECODE, S_MEMADR: alu_cls = ALU_CLS_ADD;
      S_BRANCH:                    alu_cls = ALU_CLS_SUB;
      S_EXEC_R:                    alu_cls = ALU_CLS_R;
      S_EXEC_I:                    alu_cls = ALU_CLS_I;
      default:                     alu_cls = ALU_CLS_NONE;
    endcase
  end

  mips_alu_decoder u_alu_dec (
    .cls         (alu_cls),
    .opcode      (Opcode),
    .funct       (Funct),
    .alu_control (alu_ctrl),
    .illegal     (alu_illegal)
  );

  always_comb begin
    state_d    = S_FETCH;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = 1'b0;
    ALUSrcA    = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUControl = alu_ctrl;
    Halted_o   = 1'b0;
    State_o    = state_q;

    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_BEQ:       state_d = S_BRANCH;
          default:      state_d = is_itype(Opcode) ? S_EXEC_I : ILL_NEXT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        state_d = alu_illegal ? ILL_NEXT : S_WB_R;
      end
      S_WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = (Opcode == OP_LUI) ? SRCB_IMM_HI : SRCB_IMM;
        state_d = S_WB_I;
      end
      S_WB_I: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        Branch  = 1'b1;
        PCSrc   = 1'b1;
      end
`ifdef ILLEGAL_HALT_EN
      S_HALT: begin
        Halted_o = 1'b1;
        state_d  = S_HALT;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Reset must suppress every write enable without waiting for a clock edge
    if (reset) begin
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      Branch   = 1'b0;
      Halted_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_control_unit.sv
// Scoreboard bench for mips_mc_control_unit: per-cycle expected state and
// control vectors are queued by the stimulus and checked by a negedge monitor.
module tb_mips_mc_control_unit;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] Opcode = '0;
  logic [5:0] Funct = '0;
  logic IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA;
  logic RegWrite, MemtoReg, RegDst, Halted_o;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [STATE_W-1:0] State_o;

  mips_mc_control_unit dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .Halted_o(Halted_o), .State_o(State_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Vector order: IorD MemWrite IRWrite PCWrite Branch PCSrc ALUSrcA RegWrite MemtoReg RegDst | ALUSrcB | ALUControl | Halted_o
  localparam logic [16:0] C_RST   = {10'b0000000000, 2'b01, 4'd2, 1'b0};
  localparam logic [16:0] C_FETCH = {10'b0011000000, 2'b01, 4'd2, 1'b0};
  localparam logic [16:0] C_DEC   = {10'b0000000000, 2'b10, 4'd2, 1'b0};
  localparam logic [16:0] C_MADR  = {10'b0000001000, 2'b10, 4'd2, 1'b0};
  localparam logic [16:0] C_MRD   = {10'b1000000000, 2'b00, 4'd0, 1'b0};
  localparam logic [16:0] C_MWB   = {10'b0000000110, 2'b00, 4'd0, 1'b0};
  localparam logic [16:0] C_MWR   = {10'b1100000000, 2'b00, 4'd0, 1'b0};
  localparam logic [16:0] C_WBR   = {10'b0000000101, 2'b00, 4'd0, 1'b0};
  localparam logic [16:0] C_WBI   = {10'b0000000100, 2'b00, 4'd0, 1'b0};
  localparam logic [16:0] C_BR    = {10'b0000111000, 2'b00, 4'd6, 1'b0};
  localparam logic [16:0] C_HALT  = {10'b0000000000, 2'b00, 4'd0, 1'b1};
  localparam logic [16:0] M_ALL   = 17'h1FFFF;
  localparam logic [16:0] M_NOALU = 17'h1FFE1;

  typedef struct {
    int               cyc;
    logic [3:0]       st;
    logic [16:0]      ctl;
    logic [16:0]      mask;
    string            nm;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_fail = 0;
  int    base = 0;
  string tag = "";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [3:0] st, input logic [16:0] ctl,
                      input logic [16:0] mask);
    exp_t e;
    e.cyc = base + k;
    e.st = st;
    e.ctl = ctl;
    e.mask = mask;
    e.nm = $sformatf("%s.c%0d", tag, k);
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input string t, input logic [5:0] op, input logic [5:0] fn);
    tag = t;
    Opcode = op;
    Funct = fn;
    base = cyc;
  endtask

  task automatic rtype(input string t, input logic [5:0] fn, input logic [3:0] alu);
    start(t, 6'h00, fn);
    push(0, S_FETCH, C_FETCH, M_ALL);
    push(1, S_DECODE, C_DEC, M_ALL);
    push(2, S_EXEC_R, {10'b0000001000, 2'b00, alu, 1'b0}, M_ALL);
    push(3, S_WB_R, C_WBR, M_ALL);
    step(4);
  endtask

  task automatic itype(input string t, input logic [5:0] op, input logic [1:0] bsel,
                       input logic [3:0] alu);
    start(t, op, 6'h00);
    push(0, S_FETCH, C_FETCH, M_ALL);
    push(1, S_DECODE, C_DEC, M_ALL);
    push(2, S_EXEC_I, {10'b0000001000, bsel, alu, 1'b0}, M_ALL);
    push(3, S_WB_I, C_WBI, M_ALL);
    step(4);
  endtask

  task automatic lw(input string t);
    start(t, 6'h23, 6'h00);
    push(0, S_FETCH, C_FETCH, M_ALL);
    push(1, S_DECODE, C_DEC, M_ALL);
    push(2, S_MEMADR, C_MADR, M_ALL);
    push(3, S_MEMRD, C_MRD, M_ALL);
    push(4, S_MEMWB, C_MWB, M_ALL);
    step(5);
  endtask

  // Monitor: compares the DUT against the queued expectation for this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
               mon_e.nm, mon_e.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      chk({mon_e.nm, ".state"}, 32'(State_o), 32'(mon_e.st));
      chk({mon_e.nm, ".ctl"},
          32'({IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, RegWrite,
               MemtoReg, RegDst, ALUSrcB, ALUControl, Halted_o} & mon_e.mask),
          32'(mon_e.ctl & mon_e.mask));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    tag = "reset";
    base = cyc;
    push(0, S_FETCH, C_RST, M_ALL);
    step(1);
    reset = 1'b0;

    lw("lw");

    start("sw", 6'h2B, 6'h00);
    push(0, S_FETCH, C_FETCH, M_ALL);
    push(1, S_DECODE, C_DEC, M_ALL);
    push(2, S_MEMADR, C_MADR, M_ALL);
    push(3, S_MEMWR, C_MWR, M_ALL);
    step(4);

    rtype("r_add", 6'h20, 4'd2);
    rtype("r_sub", 6'h22, 4'd6);
    rtype("r_and", 6'h24, 4'd0);
    rtype("r_or",  6'h25, 4'd1);
    rtype("r_nor", 6'h27, 4'd12);
    rtype("r_slt", 6'h2A, 4'd7);

    start("beq", 6'h04, 6'h00);
    push(0, S_FETCH, C_FETCH, M_ALL);
    push(1, S_DECODE, C_DEC, M_ALL);
    push(2, S_BRANCH, C_BR, M_ALL);
    step(3);

    itype("addi", 6'h08, 2'b10, 4'd2);
    itype("slti", 6'h0A, 2'b10, 4'd7);
    itype("andi", 6'h0C, 2'b10, 4'd0);
    itype("ori",  6'h0D, 2'b10, 4'd1);
    itype("lui",  6'h0F, 2'b11, 4'd2);

    // Reset in the middle of a store must kill MemWrite before the next edge
    start("sw_abort", 6'h2B, 6'h00);
    push(0, S_FETCH, C_FETCH, M_ALL);
    push(1, S_DECODE, C_DEC, M_ALL);
    push(2, S_MEMADR, C_MADR, M_ALL);
    push(3, S_MEMWR, C_MWR, M_ALL);
    step(3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort.memwrite", 32'(MemWrite), 32'd0);
    chk("abort.state", 32'(State_o), 32'(S_FETCH));
    chk("abort.pcwrite", 32'(PCWrite), 32'd0);
    chk("abort.irwrite", 32'(IRWrite), 32'd0);
    @(posedge clk);
    #1;
    tag = "abort_rst";
    base = cyc;
    push(0, S_FETCH, C_RST, M_ALL);
    step(1);
    reset = 1'b0;
    lw("lw_after_rst");

`ifdef ILLEGAL_HALT_EN
    start("bad_funct", 6'h00, 6'h3F);
    push(0, S_FETCH, C_FETCH, M_ALL);
    push(1, S_DECODE, C_DEC, M_ALL);
    push(2, S_EXEC_R, {10'b0000001000, 2'b00, 4'd0, 1'b0}, M_NOALU);
    for (int k = 3; k < 6; k++) push(k, S_HALT, C_HALT, M_ALL);
    step(6);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    start("bad_op", 6'h3F, 6'h00);
    push(0, S_FETCH, C_FETCH, M_ALL);
    push(1, S_DECODE, C_DEC, M_ALL);
    for (int k = 2; k < 12; k++) push(k, S_HALT, C_HALT, M_ALL);
    step(12);
`else
    start("bad_op", 6'h3F, 6'h00);
    push(0, S_FETCH, C_FETCH, M_ALL);
    push(1, S_DECODE, C_DEC, M_ALL);
    step(2);
    start("bad_funct", 6'h00, 6'h3F);
    push(0, S_FETCH, C_FETCH, M_ALL);
    push(1, S_DECODE, C_DEC, M_ALL);
    push(2, S_EXEC_R, {10'b0000001000, 2'b00, 4'd0, 1'b0}, M_NOALU);
    step(3);
    itype("addi_after_nop", 6'h08, 2'b10, 4'd2);
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
